ecc_enc_dec: RTL and testbench
==============================

// Module: ecc_enc_dec
// PURPOSE
// APB-programmable extended-Hamming (SECDED) encoder/decoder; top-level DUT of the ECC block.
// Software writes data, codeword width and noise registers, then writes CTRL to launch one operation:
//   - encode,
//   - decode, or
//   - full channel: encode, XOR noise, decode.
// Result appears on data_out with an error count and a one-cycle done pulse.
// PARAMETERS
// DATA_WIDTH       32  max codeword width; width of data_out, DATA_IN and NOISE registers
// AMBA_ADDR_WIDTH  20  PADDR width
// AMBA_WORD        32  PWDATA/PRDATA width
// PORTS
// clk             in   1                one clock; all logic on rising edge
// rst             in   1                reset is synchronous and active-high
// PADDR           in   AMBA_ADDR_WIDTH  APB address
// PWDATA          in   AMBA_WORD        APB write data
// PENABLE         in   1                APB access phase
// PSEL            in   1                APB select
// PWRITE          in   1                1=write, 0=read
// PRDATA          out  AMBA_WORD        APB read data
// data_out        out  DATA_WIDTH       codeword (encode) or corrected data (decode/full), zero-extended
// operation_done  out  1                one-cycle pulse when result valid
// num_of_errors   out  2                00 none, 01 single (corrected), 10 double (detected), 11 unused
// BEHAVIOUR
// - APB: no wait states; write when PSEL&PENABLE&PWRITE; full address compare; unmapped writes ignored, reads 0.
// - Register map:
//   - 0x00 CTRL[1:0]: 0 encode, 1 decode, 2 full channel, 3 no-op.
//   - 0x04 DATA_IN[DATA_WIDTH-1:0].
//   - 0x08 CODEWORD_WIDTH[1:0]: 0 -> n=8/k=4, 1 -> n=16/k=11, 2 or 3 -> n=32/k=26.
//   - 0x0C NOISE[DATA_WIDTH-1:0].
// - PRDATA: combinational; selected register zero-extended when PSEL&~PWRITE, else 0.
// - Codeword format:
//   - Hamming position p (1..n-1) maps to bit p-1.
//   - Parity bits at p = 1,2,4,8,16.
//   - Data bits d[0..k-1] fill the remaining positions in ascending order.
//   - Bit n-1 is the overall parity, making the XOR of all n bits 0.
//   - Bits >= n are zero.
// - Decode of word w (low n bits; higher bits ignored):
//   - s = XOR of positions whose index has that bit set; q = XOR of all n bits.
//   - q=0, s=0: 0 errors.
//   - q=1: 1 error; flip position s if s!=0, else overall bit is the error.
//   - q=0, s!=0: 2 errors, data uncorrected.
//   - 3+ errors unspecified.
// - Full channel: w = encode(DATA_IN) ^ (NOISE masked to n bits), then decode.
// - Encode sets num_of_errors=0.
// - Timing: CTRL write sampled at edge E0. data_out, num_of_errors and operation_done register at E1.
//   Done is high for exactly one cycle, then drops.
// - data_out/num_of_errors hold until next operation.
// - CTRL=3 produces no done and no output change.
// - A CTRL write while done is high starts a new operation normally (back-to-back allowed).
// - Reset: all registers, PRDATA, data_out, num_of_errors, operation_done = 0.
//   Reset during a pending operation cancels it; no done pulse follows.
// TESTING
// - Encode, width 0, DATA_IN 0xB -> data_out 0x55, errors 00, done pulse 1 cycle after CTRL write.
// - Decode, width 0, DATA_IN 0x55 -> data_out 0xB, errors 00.
// - Full channel, width 0, DATA_IN 0xB:
//   - NOISE 0x04 -> data_out 0xB, errors 01.
//   - NOISE 0x80 -> data_out 0xB, errors 01.
//   - NOISE 0x05 -> errors 10.
// - Width 2: encode 0 -> 0. Full channel with random 26-bit data, single-bit noise on every position -> data restored, errors 01.
// - APB readback: write 0x0C=0xFFFFFFFF, read 0x0C -> 0xFFFFFFFF. Read 0x10 -> 0. Read CTRL after write 2 -> 2.
// - rst=1 in cycle after CTRL write -> no done, data_out 0, registers read 0.

Source files
------------

// File: rtl/ecc_enc_dec.sv
// ecc_enc_dec
// APB-programmable extended-Hamming (SECDED) encoder/decoder.
// Software loads DATA_IN, CODEWORD_WIDTH and NOISE, then writes CTRL to launch
// one operation: encode, decode, or full channel (encode, add noise, decode).
// The result is registered one cycle after the CTRL write, together with a
// one-cycle operation_done pulse and the number of detected errors.
//
// Codeword layout for an n-bit word:
//   Hamming position p (1..n-1) lives in bit p-1.
//   Parity bits sit at the power-of-two positions.
//   Data bits fill the remaining positions in ascending order.
//   Bit n-1 holds the overall parity, so the XOR of all n bits is zero.
//   Bits at or above n are always zero.

module ecc_enc_dec #(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   input  logic                       PENABLE,
   input  logic                       PSEL,
   input  logic                       PWRITE,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       operation_done,
   output logic [1:0]                 num_of_errors
);

   // Register addresses, compared against the full PADDR.
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'(32'h00);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'(32'h04);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'(32'h08);
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'(32'h0C);

   // Operation codes held in CTRL.
   localparam logic [1:0] OP_ENCODE = 2'd0;
   localparam logic [1:0] OP_DECODE = 2'd1;
   localparam logic [1:0] OP_FULL   = 2'd2;
   localparam logic [1:0] OP_NOP    = 2'd3;

   // Error count encodings reported on num_of_errors.
   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_SINGLE = 2'd1;
   localparam logic [1:0] ERR_DOUBLE = 2'd2;

   // Decoder result: corrected data plus error classification.
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  errs;
   } dec_result_t;

   logic [1:0]            ctrl_reg;
   logic [DATA_WIDTH-1:0] data_in_reg;
   logic [1:0]            width_reg;
   logic [DATA_WIDTH-1:0] noise_reg;

   logic        wr_en;
   logic        start_op;
   logic        pending;
   logic [31:0] enc_word;
   logic [31:0] chan_word;
   logic [31:0] dec_in;
   dec_result_t dec_res;
   logic [31:0] result_data;
   logic [1:0]  result_errs;

   // Codeword length n selected by CODEWORD_WIDTH; codes 2 and 3 both mean 32.
   function automatic int code_len(input logic [1:0] w);
      case (w)
         2'd0:    code_len = 8;
         2'd1:    code_len = 16;
         default: code_len = 32;
      endcase
   endfunction

   // Mask keeping only the low n bits of a word.
   function automatic logic [31:0] width_mask(input logic [1:0] w);
      case (w)
         2'd0:    width_mask = 32'h0000_00FF;
         2'd1:    width_mask = 32'h0000_FFFF;
         default: width_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

   // Builds the extended-Hamming codeword for the low k bits of d.
   // Each data bit at position p contributes p to the syndrome; the parity
   // bits are then set to that syndrome so the full word's syndrome is zero.
   function automatic logic [31:0] hamming_encode(input logic [31:0] d,
                                                  input logic [1:0]  w);
      logic [31:0] cw;
      logic [4:0]  syn;
      logic [4:0]  bi;
      int          n;
      int          di;
      n   = code_len(w);
      cw  = '0;
      syn = '0;
      di  = 0;
      for (int p = 1; p < 32; p++) begin
         bi = 5'(p - 1);
         if ((p < n) && ((p & (p - 1)) != 0)) begin
            cw[bi] = d[5'(di)];
            if (d[5'(di)]) begin
               syn = syn ^ 5'(p);
            end
            di = di + 1;
         end
      end
      for (int j = 0; j < 5; j++) begin
         if ((1 << j) < n) begin
            cw[5'((1 << j) - 1)] = syn[3'(j)];
         end
      end
      cw[5'(n - 1)] = ^cw;
      return cw;
   endfunction

   // Decodes the low n bits of word: corrects a single error, flags a double.
   function automatic dec_result_t hamming_decode(input logic [31:0] word,
                                                  input logic [1:0]  w);
      dec_result_t res;
      logic [31:0] cw;
      logic [4:0]  syn;
      logic [4:0]  bi;
      logic        q;
      int          n;
      int          di;
      n   = code_len(w);
      cw  = word & width_mask(w);
      syn = '0;
      q   = ^cw;
      for (int p = 1; p < 32; p++) begin
         bi = 5'(p - 1);
         if ((p < n) && cw[bi]) begin
            syn = syn ^ 5'(p);
         end
      end
      res.errs = ERR_NONE;
      if (q) begin
         res.errs = ERR_SINGLE;
         if (syn != 5'd0) begin
            cw[syn - 5'd1] = ~cw[syn - 5'd1];
         end
      end else if (syn != 5'd0) begin
         res.errs = ERR_DOUBLE;
      end
      res.data = '0;
      di       = 0;
      for (int p = 1; p < 32; p++) begin
         bi = 5'(p - 1);
         if ((p < n) && ((p & (p - 1)) != 0)) begin
            res.data[5'(di)] = cw[bi];
            di = di + 1;
         end
      end
      return res;
   endfunction

   assign wr_en    = PSEL && PENABLE && PWRITE;
   assign start_op = wr_en && (PADDR == ADDR_CTRL) && (PWDATA[1:0] != OP_NOP);

   // APB register writes; unmapped addresses are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_reg    <= '0;
         data_in_reg <= '0;
         width_reg   <= '0;
         noise_reg   <= '0;
      end else if (wr_en) begin
         case (PADDR)
            ADDR_CTRL:  ctrl_reg    <= PWDATA[1:0];
            ADDR_DATA:  data_in_reg <= DATA_WIDTH'(PWDATA);
            ADDR_WIDTH: width_reg   <= PWDATA[1:0];
            ADDR_NOISE: noise_reg   <= DATA_WIDTH'(PWDATA);
            default: ;
         endcase
      end
   end

   // Combinational read mux; anything other than a mapped read returns zero.
   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (PADDR)
            ADDR_CTRL:  PRDATA = AMBA_WORD'(ctrl_reg);
            ADDR_DATA:  PRDATA = AMBA_WORD'(data_in_reg);
            ADDR_WIDTH: PRDATA = AMBA_WORD'(width_reg);
            ADDR_NOISE: PRDATA = AMBA_WORD'(noise_reg);
            default:    PRDATA = '0;
         endcase
      end
   end

   // Datapath: encode, channel noise, decode and result selection by CTRL.
   always_comb begin
      enc_word  = hamming_encode(32'(data_in_reg), width_reg);
      chan_word = enc_word ^ (32'(noise_reg) & width_mask(width_reg));
      dec_in    = (ctrl_reg == OP_FULL) ? chan_word : 32'(data_in_reg);
      dec_res   = hamming_decode(dec_in, width_reg);
      if (ctrl_reg == OP_ENCODE) begin
         result_data = enc_word;
         result_errs = ERR_NONE;
      end else begin
         result_data = dec_res.data;
         result_errs = dec_res.errs;
      end
   end

   // Launch tracking and result registers; done follows the launch by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending        <= 1'b0;
         operation_done <= 1'b0;
         data_out       <= '0;
         num_of_errors  <= ERR_NONE;
      end else begin
         pending        <= start_op;
         operation_done <= pending;
         if (pending) begin
            data_out      <= DATA_WIDTH'(result_data);
            num_of_errors <= result_errs;
         end
      end
   end

endmodule

// File: tb/tb_ecc_enc_dec.sv
// tb_ecc_enc_dec
// Directed bench for ecc_enc_dec: APB register access, encode/decode/full
// channel results against hand-computed vectors, done timing and reset.

module tb_ecc_enc_dec;

   localparam logic [19:0] ADDR_CTRL  = 20'h00;
   localparam logic [19:0] ADDR_DATA  = 20'h04;
   localparam logic [19:0] ADDR_WIDTH = 20'h08;
   localparam logic [19:0] ADDR_NOISE = 20'h0C;
   localparam logic [19:0] ADDR_BAD   = 20'h10;

   logic        clk;
   logic        rst;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic        PENABLE;
   logic        PSEL;
   logic        PWRITE;
   logic [31:0] PRDATA;
   logic [31:0] data_out;
   logic        operation_done;
   logic [1:0]  num_of_errors;

   int assertCount;
   int failCount;

   ecc_enc_dec #(
      .DATA_WIDTH(32),
      .AMBA_ADDR_WIDTH(20),
      .AMBA_WORD(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PENABLE(PENABLE),
      .PSEL(PSEL),
      .PWRITE(PWRITE),
      .PRDATA(PRDATA),
      .data_out(data_out),
      .operation_done(operation_done),
      .num_of_errors(num_of_errors)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // APB write; called just after a negedge, returns at the negedge after the write edge.
   task automatic apbWrite(input logic [19:0] addr, input logic [31:0] data);
      PSEL    = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = addr;
      PWDATA  = data;
      PENABLE = 1'b0;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   // APB read; PRDATA is combinational so it is sampled during the setup phase.
   task automatic apbRead(input logic [19:0] addr, output logic [31:0] data);
      PSEL    = 1'b1;
      PWRITE  = 1'b0;
      PADDR   = addr;
      PENABLE = 1'b0;
      #1;
      data = PRDATA;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   // Launches one operation and checks done timing, data and error count.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] expData,
                                input logic [1:0] expErr, input string tag);
      apbWrite(ADDR_CTRL, {30'd0, op});
      checkOutput({tag, " done before E1"}, {31'd0, operation_done}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " done at E1"}, {31'd0, operation_done}, 32'd1);
      checkOutput({tag, " data"}, data_out, expData);
      checkOutput({tag, " errors"}, {30'd0, num_of_errors}, {30'd0, expErr});
      @(posedge clk);
      #1;
      checkOutput({tag, " done drops"}, {31'd0, operation_done}, 32'd0);
      @(negedge clk);
   endtask

   // Directed test sequence.
   initial begin
      logic [31:0] rd;
      logic [31:0] rnd;
      assertCount = 0;
      failCount   = 0;
      rst     = 1'b1;
      PADDR   = '0;
      PWDATA  = '0;
      PENABLE = 1'b0;
      PSEL    = 1'b0;
      PWRITE  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      checkOutput("reset data_out", data_out, 32'd0);
      checkOutput("reset errors", {30'd0, num_of_errors}, 32'd0);
      checkOutput("reset done", {31'd0, operation_done}, 32'd0);
      apbRead(ADDR_CTRL, rd);
      checkOutput("reset CTRL", rd, 32'd0);
      apbRead(ADDR_DATA, rd);
      checkOutput("reset DATA_IN", rd, 32'd0);
      apbRead(ADDR_WIDTH, rd);
      checkOutput("reset WIDTH", rd, 32'd0);
      apbRead(ADDR_NOISE, rd);
      checkOutput("reset NOISE", rd, 32'd0);

      // Width 0 (n=8, k=4) vectors.
      apbWrite(ADDR_WIDTH, 32'd0);
      apbWrite(ADDR_DATA, 32'hB);
      applyStimulus(2'd0, 32'h55, 2'd0, "enc w0 0xB");
      apbWrite(ADDR_DATA, 32'h55);
      applyStimulus(2'd1, 32'hB, 2'd0, "dec w0 0x55");
      apbWrite(ADDR_DATA, 32'hFFFF_FF55);
      applyStimulus(2'd1, 32'hB, 2'd0, "dec w0 upper ignored");
      apbWrite(ADDR_DATA, 32'hB);
      apbWrite(ADDR_NOISE, 32'h04);
      applyStimulus(2'd2, 32'hB, 2'd1, "full noise 0x04");
      apbWrite(ADDR_NOISE, 32'h80);
      applyStimulus(2'd2, 32'hB, 2'd1, "full noise 0x80");
      apbWrite(ADDR_NOISE, 32'h05);
      applyStimulus(2'd2, 32'hA, 2'd2, "full noise 0x05");
      apbWrite(ADDR_NOISE, 32'h100);
      applyStimulus(2'd2, 32'hB, 2'd0, "full noise masked");

      // Back-to-back: second CTRL write lands on the edge where done drops.
      apbWrite(ADDR_CTRL, 32'd0);
      fork
         apbWrite(ADDR_CTRL, 32'd1);
         begin
            @(posedge clk);
            #1;
            checkOutput("b2b first done", {31'd0, operation_done}, 32'd1);
            checkOutput("b2b first data", data_out, 32'h55);
         end
      join
      @(posedge clk);
      #1;
      checkOutput("b2b second done", {31'd0, operation_done}, 32'd1);
      checkOutput("b2b second data", data_out, 32'h8);
      checkOutput("b2b second errors", {30'd0, num_of_errors}, 32'd1);
      @(negedge clk);

      // CTRL=3 is a no-op: no done pulse and outputs hold.
      apbWrite(ADDR_CTRL, 32'd3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("nop done", {31'd0, operation_done}, 32'd0);
      end
      checkOutput("nop data held", data_out, 32'h8);
      checkOutput("nop errors held", {30'd0, num_of_errors}, 32'd1);
      @(negedge clk);

      // Width 1 (n=16, k=11): overall-parity error and masked noise.
      apbWrite(ADDR_WIDTH, 32'd1);
      apbWrite(ADDR_DATA, 32'h7FF);
      apbWrite(ADDR_NOISE, 32'h8000);
      applyStimulus(2'd2, 32'h7FF, 2'd1, "full w1 overall bit");
      apbWrite(ADDR_NOISE, 32'h1_0000);
      applyStimulus(2'd2, 32'h7FF, 2'd0, "full w1 masked");

      // Width 2 (n=32, k=26): zero word and single-bit noise on every position.
      apbWrite(ADDR_WIDTH, 32'd2);
      apbWrite(ADDR_DATA, 32'd0);
      applyStimulus(2'd0, 32'd0, 2'd0, "enc w2 zero");
      for (int pos = 0; pos < 32; pos++) begin
         rnd = $urandom() & 32'h03FF_FFFF;
         apbWrite(ADDR_DATA, rnd);
         apbWrite(ADDR_NOISE, 32'd1 << pos);
         applyStimulus(2'd2, rnd, 2'd1, $sformatf("full w2 pos %0d", pos));
      end

      // APB readback and unmapped address.
      apbWrite(ADDR_NOISE, 32'hFFFF_FFFF);
      apbRead(ADDR_NOISE, rd);
      checkOutput("read NOISE", rd, 32'hFFFF_FFFF);
      apbRead(ADDR_BAD, rd);
      checkOutput("read unmapped", rd, 32'd0);
      apbWrite(ADDR_CTRL, 32'd2);
      apbRead(ADDR_CTRL, rd);
      checkOutput("read CTRL", rd, 32'd2);
      apbRead(ADDR_WIDTH, rd);
      checkOutput("read WIDTH", rd, 32'd2);

      // Reset immediately after a CTRL write cancels the pending operation.
      apbWrite(ADDR_WIDTH, 32'd0);
      apbWrite(ADDR_DATA, 32'hB);
      applyStimulus(2'd0, 32'h55, 2'd0, "pre-reset enc");
      apbWrite(ADDR_CTRL, 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst done", {31'd0, operation_done}, 32'd0);
      checkOutput("rst data_out", data_out, 32'd0);
      checkOutput("rst errors", {30'd0, num_of_errors}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checkOutput("post-rst no done", {31'd0, operation_done}, 32'd0);
      end
      @(negedge clk);
      apbRead(ADDR_CTRL, rd);
      checkOutput("post-rst CTRL", rd, 32'd0);
      apbRead(ADDR_DATA, rd);
      checkOutput("post-rst DATA_IN", rd, 32'd0);
      apbRead(ADDR_NOISE, rd);
      checkOutput("post-rst NOISE", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
